// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} loader_state_t;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         WORD_WIDTH     = 32;
    localparam int         BYTES_PER_WORD = WORD_WIDTH / 8;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the loader; expired stays high once the limit is reached
// until cleared.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame-driven instruction memory writer: sync 0xA5, word count N, then 4*N
// little-endian bytes written to imem from word address 0 while the core is held.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    loader_state_t         state, state_next;
    logic                  accept, in_frame, expired;
    logic                  len_bad, lane_last, word_last;
    logic [ADDR_WIDTH:0]   len, word_cnt;
    logic [LANE_W-1:0]     byte_cnt;
    logic [DATA_WIDTH-1:0] word_buf;

    assign in_frame  = (state == LEN) || (state == DATA);
    assign rx_ready  = !rst && ((state == IDLE) || in_frame);
    assign accept    = rx_valid && rx_ready;
    assign done      = (state == DONE);
    assign len_bad   = (rx_data == 8'd0) || (int'(rx_data) > DEPTH);
    assign lane_last = (byte_cnt == LANE_W'(BYTES_PER_WORD - 1));
    assign word_last = (word_cnt == len - 1'b1);

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept || !in_frame),
        .enable (in_frame),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An accepted byte takes priority over an expiring timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && rx_data == SYNC_BYTE) state_next = LEN;
            LEN: begin
                if (accept)       state_next = len_bad ? ERROR : DATA;
                else if (expired) state_next = ERROR;
            end
            DATA: begin
                if (accept) begin
                    if (lane_last && word_last) state_next = DONE;
                end else if (expired) begin
                    state_next = ERROR;
                end
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            err       <= 1'b0;
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            word_buf  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                    end
                end
                LEN: begin
                    if (accept && !len_bad) begin
                        len      <= rx_data[ADDR_WIDTH:0];
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_buf[byte_cnt*8 +: 8] <= rx_data;
                        byte_cnt                  <= byte_cnt + 1'b1;
                        if (lane_last) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {rx_data, word_buf[DATA_WIDTH-9:0]};
                            mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                            word_cnt  <= word_cnt + 1'b1;
                        end
                    end
                end
                DONE: cpu_hold <= 1'b0;
                ERROR: begin
                    cpu_hold <= 1'b0;
                    err      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
